pixel_stream_fifo: RTL and testbench

//   AXI-Stream buffer placed directly downstream of pixel_generator. Absorbs backpressure from the

---
 rtl/pixel_stream_fifo.sv | 93 +++++++++
 tb/tb_pixel_stream_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_fifo.sv
// pixel_stream_fifo: AXI-Stream first-word-fall-through buffer with SOF/EOL framing checker
//   stream_aclk, periph_reset : single clock and its synchronous active-high reset
//   in_stream_*               : upstream beats; tready is driven from the registered fill count only
//   out_stream_*              : buffered beats in arrival order; outputs read zero when the FIFO is empty
//   err_clear                 : pulse that clears the sticky err_sof/err_eol flags
//   frame_count, fill_level   : frames completed at the input, entries currently held
module pixel_stream_fifo #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int X_BEATS = 480,
  parameter int Y_LINES = 480
) (
  input  logic                       stream_aclk,
  input  logic                       periph_reset,
  input  logic [DATA_W-1:0]          in_stream_tdata,
  input  logic [DATA_W/8-1:0]        in_stream_tkeep,
  input  logic                       in_stream_tlast,
  input  logic                       in_stream_tuser,
  input  logic                       in_stream_tvalid,
  output logic                       in_stream_tready,
  output logic [DATA_W-1:0]          out_stream_tdata,
  output logic [DATA_W/8-1:0]        out_stream_tkeep,
  output logic                       out_stream_tlast,
  output logic                       out_stream_tuser,
  output logic                       out_stream_tvalid,
  input  logic                       out_stream_tready,
  input  logic                       err_clear,
  output logic                       err_sof,
  output logic                       err_eol,
  output logic [15:0]                frame_count,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);
  localparam int EW = DATA_W + DATA_W/8 + 2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int XW = $clog2(X_BEATS+1);
  localparam int YW = $clog2(Y_LINES+1);
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, push, pop, line_end;
  logic [XW-1:0] x_q, x_d, xs;
  logic [YW-1:0] y_q, y_d, ys;
  logic [15:0]   frame_q, frame_d;
  logic          sof_q, sof_d, eol_q, eol_d;
  assign push  = in_stream_tvalid && rdy_q;
  assign pop   = (cnt_q != '0) && out_stream_tready;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  assign in_stream_tready  = rdy_q;
  assign out_stream_tvalid = cnt_q != '0;
  assign {out_stream_tuser, out_stream_tlast, out_stream_tkeep, out_stream_tdata} =
    out_stream_tvalid ? mem_q[rd_q] : '0;
  assign err_sof     = sof_q;
  assign err_eol     = eol_q;
  assign frame_count = frame_q;
  assign fill_level  = cnt_q;
  // A tuser beat is treated as beat 0 of line 0, so the line-end rules still apply to it
  always_comb begin
    xs       = in_stream_tuser ? '0 : x_q;
    ys       = in_stream_tuser ? '0 : y_q;
    line_end = in_stream_tlast || xs == XW'(X_BEATS-1);
    x_d      = !push ? x_q : line_end ? '0 : xs + XW'(1);
    y_d      = !push ? y_q : !line_end ? ys : ys == YW'(Y_LINES-1) ? '0 : ys + YW'(1);
    frame_d  = frame_q + 16'(push && line_end && ys == YW'(Y_LINES-1));
    sof_d    = (sof_q && !err_clear) || (push && in_stream_tuser != (x_q == '0 && y_q == '0));
    eol_d    = (eol_q && !err_clear) || (push && in_stream_tlast != (x_q == XW'(X_BEATS-1)));
  end
  always_ff @(posedge stream_aclk)
    if (push) mem_q[wr_q] <= {in_stream_tuser, in_stream_tlast, in_stream_tkeep, in_stream_tdata};
  always_ff @(posedge stream_aclk) begin
    if (periph_reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_d;
      rdy_q   <= cnt_d != CW'(DEPTH);
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
    end
  end
endmodule

// File: tb/tb_pixel_stream_fifo.sv
// tb_pixel_stream_fifo: directed table and scoreboard checks for pixel_stream_fifo
module tb_pixel_stream_fifo;
  localparam int DEPTH = 16, XB = 8, YL = 4, FB = XB * YL;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] in_data, out_data;
  logic [3:0]  in_keep, out_keep;
  logic in_last, in_user, in_valid, in_ready;
  logic out_last, out_user, out_valid, out_ready;
  logic err_clear, err_sof, err_eol;
  logic [15:0] frame_count;
  logic [4:0]  fill_level;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  pixel_stream_fifo #(.DATA_W(32), .DEPTH(DEPTH), .X_BEATS(XB), .Y_LINES(YL)) dut (
    .stream_aclk(clk), .periph_reset(rst),
    .in_stream_tdata(in_data), .in_stream_tkeep(in_keep), .in_stream_tlast(in_last),
    .in_stream_tuser(in_user), .in_stream_tvalid(in_valid), .in_stream_tready(in_ready),
    .out_stream_tdata(out_data), .out_stream_tkeep(out_keep), .out_stream_tlast(out_last),
    .out_stream_tuser(out_user), .out_stream_tvalid(out_valid), .out_stream_tready(out_ready),
    .err_clear(err_clear), .err_sof(err_sof), .err_eol(err_eol),
    .frame_count(frame_count), .fill_level(fill_level)
  );
  typedef struct {
    logic v, u, r;
    logic [31:0] d;
    logic [4:0] fill;
    logic tv, rdy;
    logic [31:0] od;
  } vec_t;
  vec_t tbl [9];
  logic [37:0] q [$];
  bit mrdy, chk, esof, eeol, inj_user, inj_last;
  int mx, my, p;
  logic [15:0] mfc;
  logic [31:0] d;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(bit v, bit ordy, bit clr);
    bit push, pop;
    logic [37:0] head;
    in_valid = v; out_ready = ordy; err_clear = clr;
    in_user = (p == 0) || inj_user;
    in_last = (p % XB == XB - 1) || inj_last;
    in_data = d;
    in_keep = d[3:0] ^ 4'hA;
    push = !rst && v && mrdy;
    pop  = !rst && q.size() != 0 && ordy;
    if (chk) begin
      head = q.size() != 0 ? q[0] : '0;
      check("in_tready", in_ready, mrdy);
      check("out_tvalid", out_valid, q.size() != 0);
      check("fill_level", fill_level, q.size());
      check("out_head", {out_user, out_last, out_keep, out_data}, head);
      check("err_sof", err_sof, esof);
      check("err_eol", err_eol, eeol);
      check("frame_count", frame_count, mfc);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      mrdy = 0; esof = 0; eeol = 0; mx = 0; my = 0; mfc = 0; p = 0; chk = 1;
    end else begin
      if (clr) begin esof = 0; eeol = 0; end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (in_user != (mx == 0 && my == 0)) esof = 1;
        if (in_last != (mx == XB - 1)) eeol = 1;
        if (in_user) begin mx = 0; my = 0; end
        if (in_last || mx == XB - 1) begin
          mx = 0;
          if (my == YL - 1) begin my = 0; mfc++; end else my++;
        end else mx++;
        q.push_back({in_user, in_last, in_keep, in_data});
        p = (p + 1) % FB;
        d++;
      end
      mrdy = q.size() != DEPTH;
    end
    #1;
  endtask
  task automatic send(int n, bit ordy, bit clr);
    logic [31:0] d0;
    d0 = d;
    for (int i = 0; i < 400 && int'(d - d0) < n; i++) tick(1, ordy, clr && i == 0);
    check("send_budget", d - d0, n);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) tick(0, 1, 0);
    check("drain_empty", fill_level, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{0, 0, 0, 32'h0,  5'd0, 0, 1, 32'h0};
    tbl[1] = '{1, 1, 0, 32'hA0, 5'd1, 1, 1, 32'hA0};
    tbl[2] = '{1, 0, 0, 32'hA1, 5'd2, 1, 1, 32'hA0};
    tbl[3] = '{0, 0, 1, 32'h0,  5'd1, 1, 1, 32'hA1};
    tbl[4] = '{1, 0, 1, 32'hA2, 5'd1, 1, 1, 32'hA2};
    tbl[5] = '{0, 0, 1, 32'h0,  5'd0, 0, 1, 32'h0};
    tbl[6] = '{1, 0, 1, 32'hA3, 5'd1, 1, 1, 32'hA3};
    tbl[7] = '{0, 0, 0, 32'h0,  5'd1, 1, 1, 32'hA3};
    tbl[8] = '{0, 0, 1, 32'h0,  5'd0, 0, 1, 32'h0};
    in_valid = 0; out_ready = 0; err_clear = 0; in_data = 0; in_keep = 0; in_last = 0; in_user = 0;
    p = 0; d = 32'h100; inj_user = 0; inj_last = 0; chk = 0;
    rst = 1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst = 0;
    foreach (tbl[i]) begin
      in_valid = tbl[i].v; in_user = tbl[i].u; in_last = 0; in_data = tbl[i].d; in_keep = 0;
      out_ready = tbl[i].r; err_clear = 0;
      @(posedge clk); #1;
      check("tbl_fill", fill_level, tbl[i].fill);
      check("tbl_tvalid", out_valid, tbl[i].tv);
      check("tbl_tready", in_ready, tbl[i].rdy);
      check("tbl_tdata", out_data, tbl[i].od);
    end
    chk = 0; rst = 1;
    tick(0, 0, 0);
    rst = 0;
    tick(0, 0, 0);
    repeat (16) tick(1, 0, 0);
    check("t1_fill_full", fill_level, 16);
    check("t1_tready_low", in_ready, 0);
    check("t1_head_first", out_data, 32'h100);
    tick(1, 0, 0);
    check("t1_17th_refused", fill_level, 16);
    repeat (20) tick(1, 1, 0);
    check("t2_fill_steady", fill_level, 15);
    check("t2_tvalid", out_valid, 1);
    drain();
    rst = 1;
    tick(0, 0, 0);
    rst = 0;
    tick(0, 0, 0);
    begin
      logic [31:0] d0;
      d0 = d;
      for (int i = 0; i < 2000 && int'(d - d0) < 2 * FB; i++) tick(1, 1'($urandom_range(0, 1)), 0);
      check("t3_beats", d - d0, 2 * FB);
    end
    drain();
    check("t3_frames", frame_count, 2);
    check("t3_sof_clean", err_sof, 0);
    check("t3_eol_clean", err_eol, 0);
    send(3, 1, 0);
    inj_last = 1;
    send(1, 1, 0);
    inj_last = 0;
    p = XB;
    check("t4_eol_set", err_eol, 1);
    check("t4_sof_clean", err_sof, 0);
    tick(0, 1, 1);
    check("t4_eol_cleared", err_eol, 0);
    send(3 * XB, 1, 0);
    check("t4_eol_stays_clear", err_eol, 0);
    check("t4_frames", frame_count, 3);
    send(XB + 5, 1, 0);
    inj_user = 1;
    send(1, 1, 1);
    inj_user = 0;
    p = 1;
    check("t5_sof_wins_clear", err_sof, 1);
    send(FB - 1, 1, 0);
    check("t5_frames", frame_count, 4);
    check("t5_eol_clean", err_eol, 0);
    for (int i = 0; i < 50 && q.size() < 7; i++) tick(1, 0, 0);
    check("t6_buffered", fill_level, 7);
    rst = 1;
    tick(1, 0, 0);
    rst = 0;
    check("t6_tvalid", out_valid, 0);
    check("t6_fill", fill_level, 0);
    check("t6_sof", err_sof, 0);
    check("t6_frames", frame_count, 0);
    check("t6_tready_in_reset", in_ready, 0);
    tick(0, 0, 0);
    check("t6_tready_after", in_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
